// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester/response bundle for the shared ALU arbiter
//
// Purpose: groups the request and response handshake signals of alu_share_arbiter.
// Ports (signals):
//   req_valid [NREQ]      request i valid
//   req_ready [NREQ]      request i accepted this cycle (one-hot or zero)
//   req_a     [NREQ*32]   operand A of requester i, bits [32*i+31:32*i]
//   req_b     [NREQ*32]   operand B of requester i
//   req_sel   [NREQ*4]    ALU select code of requester i
//   rsp_valid             response register holds a result
//   rsp_ready             consumer takes response this cycle
//   rsp_data  [32]        result
//   rsp_id    [IDW]       index of requester owning the response
//   rsp_err               select code was illegal
// Modports: master = requesters + response consumer, slave = arbiter.

interface alu_share_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*4-1:0]  req_sel;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational 32-bit ALU
//
// Purpose: arbitrates NREQ requesters round-robin onto a single combinational ALU,
// drives the ALU operand/select lines for the granted requester and captures the
// result in a response register with valid/ready handshake. One transaction per
// cycle at full rate.
// Ports:
//   clk      in   system clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset
//   bus      slave modport of alu_share_arbiter_if (request/response handshakes)
//   alu_a    out  ALU operand A
//   alu_b    out  ALU operand B
//   alu_sel  out  ALU select code (4'b1111 = pass A when idle or illegal)
//   alu_out  in   ALU result (combinational)

module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_sel,
  input  logic [31:0]          alu_out
);

  localparam logic [3:0] SEL_SLT  = 4'b1000;
  localparam logic [3:0] SEL_SLTU = 4'b1001;
  localparam logic [3:0] SEL_PASS = 4'b1111;

  // Unpacked per-requester views of the flat request buses.
  logic [31:0] a_arr   [NREQ];
  logic [31:0] b_arr   [NREQ];
  logic [3:0]  sel_arr [NREQ];
  logic        vld_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]   = bus.req_a[32*i +: 32];
      b_arr[i]   = bus.req_b[32*i +: 32];
      sel_arr[i] = bus.req_sel[4*i +: 4];
      vld_arr[i] = bus.req_valid[i];
    end
  end

  // Round-robin pointer: index of the last granted requester. Reset value NREQ-1
  // makes requester 0 the first one searched.
  logic [IDW-1:0] last_grant;

  logic           found;
  logic [IDW-1:0] gidx;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int             tmp;
      logic [IDW-1:0] cand;
      tmp  = (int'(last_grant) + 1 + k) % NREQ;
      cand = IDW'(tmp);
      if (!found && vld_arr[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  // A new result may be captured when the register is empty or being drained
  // this same cycle, so back-to-back grants need no bubble.
  logic can_issue;
  logic gnt;

  assign can_issue = !bus.rsp_valid || bus.rsp_ready;
  assign gnt       = rst_n && can_issue && found;

  logic [NREQ-1:0] ready;

  always_comb begin
    ready = '0;
    if (gnt) begin
      ready[gidx] = 1'b1;
    end
  end

  assign bus.req_ready = ready;

  // Select codes 1010..1101 are illegal; those requests are still accepted but
  // the ALU only ever sees the pass-through code.
  logic [3:0] g_sel;
  logic       illegal;

  assign g_sel   = sel_arr[gidx];
  assign illegal = (g_sel >= 4'b1010) && (g_sel <= 4'b1101);

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = SEL_PASS;
    if (gnt) begin
      alu_a   = a_arr[gidx];
      alu_b   = b_arr[gidx];
      alu_sel = illegal ? SEL_PASS : g_sel;
    end
  end

  // SLT/SLTU only define bit 0 of the ALU output; the rest is masked off.
  logic [31:0] cap_data;

  always_comb begin
    cap_data = alu_out;
    if (illegal) begin
      cap_data = '0;
    end else if (g_sel == SEL_SLT || g_sel == SEL_SLTU) begin
      cap_data = {31'b0, alu_out[0]};
    end
  end

  logic           rsp_valid_q;
  logic [31:0]    rsp_data_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      last_grant  <= IDW'(NREQ - 1);
    end else if (gnt) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= cap_data;
      rsp_id_q    <= gidx;
      rsp_err_q   <= illegal;
      last_grant  <= gidx;
    end else if (bus.rsp_ready) begin
      // Drained with nothing new: only valid drops, payload is left as-is.
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter

module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;

  int errors;
  int checks;

  alu_share_arbiter_if #(.NREQ(2)) bus ();

  alu_share_arbiter #(.NREQ(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_out (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model; SLT/SLTU deliberately leave junk in bits 31:1.
  always_comb begin
    case (alu_sel)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd2:    alu_out = alu_a & alu_b;
      4'd3:    alu_out = alu_a | alu_b;
      4'd4:    alu_out = alu_a ^ alu_b;
      4'd5:    alu_out = alu_a << alu_b[4:0];
      4'd6:    alu_out = alu_a >> alu_b[4:0];
      4'd7:    alu_out = $signed(alu_a) >>> alu_b[4:0];
      4'd8:    alu_out = {alu_a[31:1], $signed(alu_a) < $signed(alu_b)};
      4'd9:    alu_out = {alu_a[31:1], alu_a < alu_b};
      4'd14:   alu_out = alu_b;
      4'd15:   alu_out = alu_a;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_sel[4*i +: 4] = sel;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [31:0] d,
                           input logic id, input logic e);
    check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(v));
    check({tag, ".rsp_data"},  64'(bus.rsp_data),  64'(d));
    check({tag, ".rsp_id"},    64'(bus.rsp_id),    64'(id));
    check({tag, ".rsp_err"},   64'(bus.rsp_err),   64'(e));
  endtask

  initial begin
    logic [1:0]  exp_rdy [4];
    logic [31:0] exp_dat [4];
    errors = 0;
    checks = 0;

    // Reset: outputs at reset values, req_ready held low even with a valid request.
    rst_n         = 1'b0;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.req_ready", 64'(bus.req_ready), 64'd0);
    check_rsp("reset", 1'b0, 32'd0, 1'b0, 1'b0);

    // 1: single add from requester 0.
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 32'd5, 32'd7, 4'b0000);
    bus.req_valid = 2'b01;
    #1;
    check("t1.req_ready", 64'(bus.req_ready), 64'b01);
    check("t1.alu_a", 64'(alu_a), 64'd5);
    check("t1.alu_sel", 64'(alu_sel), 64'd0);
    @(posedge clk); #1;
    check_rsp("t1", 1'b1, 32'd12, 1'b0, 1'b0);

    // Idle: defined ALU drive, response drains.
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    check("idle.req_ready", 64'(bus.req_ready), 64'd0);
    check("idle.alu_a", 64'(alu_a), 64'd0);
    check("idle.alu_b", 64'(alu_b), 64'd0);
    check("idle.alu_sel", 64'(alu_sel), 64'hF);
    @(posedge clk); #1;
    check("idle.rsp_valid", 64'(bus.rsp_valid), 64'd0);

    // 2: both requesting every cycle; last grant was 0 so order is 1,0,1,0.
    set_req(0, 32'd1, 32'd2, 4'b0000);    // 3
    set_req(1, 32'd10, 32'd3, 4'b0001);   // 7
    exp_rdy = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_dat = '{32'd7, 32'd3, 32'd7, 32'd3};
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      bus.req_valid = 2'b11;
      #1;
      check($sformatf("t2.req_ready[%0d]", n), 64'(bus.req_ready), 64'(exp_rdy[n]));
      @(posedge clk); #1;
      check_rsp($sformatf("t2[%0d]", n), 1'b1, exp_dat[n], exp_rdy[n][1], 1'b0);
    end

    // 3: SLT / SLTU from requester 1; upper bits must be cleared.
    @(negedge clk);
    bus.req_valid = 2'b10;
    set_req(1, 32'hFFFF_FFFF, 32'd1, 4'b1000);
    @(posedge clk); #1;
    check_rsp("t3.slt", 1'b1, 32'h0000_0001, 1'b1, 1'b0);
    @(negedge clk);
    set_req(1, 32'hFFFF_FFFF, 32'd1, 4'b1001);
    @(posedge clk); #1;
    check_rsp("t3.sltu", 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // 4: backpressure for 3 cycles, then resume after the held rsp_id (1 -> 0).
    set_req(0, 32'd1, 32'd2, 4'b0000);
    set_req(1, 32'd10, 32'd3, 4'b0001);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.req_valid = 2'b11;
      bus.rsp_ready = 1'b0;
      #1;
      check($sformatf("t4.req_ready[%0d]", n), 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
      check_rsp($sformatf("t4.hold[%0d]", n), 1'b1, 32'd0, 1'b1, 1'b0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    check("t4.resume.req_ready", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    check_rsp("t4.resume", 1'b1, 32'd3, 1'b0, 1'b0);

    // 5: illegal code accepted, ALU sees pass-through, error flagged; then clears.
    @(negedge clk);
    bus.req_valid = 2'b01;
    set_req(0, 32'd9, 32'd4, 4'b1011);
    #1;
    check("t5.req_ready", 64'(bus.req_ready), 64'b01);
    check("t5.alu_sel", 64'(alu_sel), 64'hF);
    @(posedge clk); #1;
    check_rsp("t5.illegal", 1'b1, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    set_req(0, 32'd2, 32'd2, 4'b0000);
    @(posedge clk); #1;
    check_rsp("t5.legal", 1'b1, 32'd4, 1'b0, 1'b0);

    // 6: async reset with a pending response; pointer was 0, reset makes req0 first.
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check_rsp("t6.async", 1'b0, 32'd0, 1'b0, 1'b0);
    bus.req_valid = 2'b11;
    set_req(0, 32'd1, 32'd2, 4'b0000);
    #1;
    check("t6.in_reset.req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6.first.req_ready", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    check_rsp("t6.first", 1'b1, 32'd3, 1'b0, 1'b0);

    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
